// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encodings
// and the ISR status word layout.
package int_ctrl_pkg;
  localparam int N_SRC = 6;

  localparam logic [1:0] IC_MASK = 2'd0;
  localparam logic [1:0] IC_PEND = 2'd1;
  localparam logic [1:0] IC_EDGE = 2'd2;
  localparam logic [1:0] IC_ISR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } ic_state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } isr_t;

  // Id bits read as zero whenever nothing is in service.
  function automatic logic [31:0] isr_word(input isr_t s);
    return s.vld ? {1'b1, 28'b0, s.id} : 32'b0;
  endfunction
endpackage

// File: rtl/int_ctrl_prio_enc6.sv
// Fixed-priority encoder for six sources; the lowest set index wins.
module prio_enc6 (
  input  logic [5:0] eligible,
  output logic       any,
  output logic [2:0] id
);
  always_comb begin
    any = |eligible;
    id  = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (eligible[i]) id = 3'(i);
  end
endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches peripheral requests, arbitrates by mask/priority and
// runs the request/ack/service handshake with CP0, plus the bridge register file.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  irq_in,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [5:0]  hw_int,
  input  logic        int_ack,
  input  logic        eret
);
  ic_state_e  state;
  logic [2:0] id;
  logic [5:0] mask, pend, edge_m, irq_prev;
  logic [5:0] set_v, w1c, ack_clr, pend_nxt, eligible;
  logic [2:0] win_id;
  logic       win_any, wr_en, hold;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[31:6];
  assign eligible     = pend & mask;

  prio_enc6 u_prio (
    .eligible (eligible),
    .any      (win_any),
    .id       (win_id)
  );

  always_comb begin
    wr_en   = sel & we;
    w1c     = (wr_en && addr == IC_PEND) ? wdata[5:0] : 6'd0;
    set_v   = (edge_m & irq_in & ~irq_prev) | (~edge_m & irq_in);
    hold    = mask[id] & pend[id];
    ack_clr = (state == ST_REQ && hold && int_ack && edge_m[id]) ? (6'd1 << id) : 6'd0;
    // New events are OR-ed in last so a set beats a same-cycle clear.
    pend_nxt = (pend & ~w1c & ~ack_clr) | set_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= '0;
      pend     <= '0;
      edge_m   <= '0;
      irq_prev <= '0;
      state    <= ST_IDLE;
      id       <= '0;
      hw_int   <= '0;
    end else begin
      irq_prev <= irq_in;
      pend     <= pend_nxt;
      if (wr_en && addr == IC_MASK) mask   <= wdata[5:0];
      if (wr_en && addr == IC_EDGE) edge_m <= wdata[5:0];
      case (state)
        ST_IDLE: begin
          hw_int <= '0;
          if (win_any) begin
            id    <= win_id;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!hold) begin
            hw_int <= '0;
            state  <= ST_IDLE;
          end else if (int_ack) begin
            hw_int <= '0;
            state  <= ST_SVC;
          end else begin
            hw_int <= 6'd1 << id;
          end
        end
        ST_SVC: begin
          hw_int <= '0;
          if (eret) state <= ST_IDLE;
        end
        default: begin
          hw_int <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr)
        IC_MASK: rdata = {26'd0, mask};
        IC_PEND: rdata = {26'd0, pend};
        IC_EDGE: rdata = {26'd0, edge_m};
        IC_ISR:  rdata = isr_word('{vld: (state == ST_SVC), id: id});
        default: rdata = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: register access, latency, priority, level/edge modes,
// mask drop in REQ, set-vs-clear collision and reset during service.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, sel, we, int_ack, eret;
  logic [5:0]  irq_in, hw_int;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  int          total = 0, bad = 0;

  int_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .hw_int  (hw_int),
    .int_ack (int_ack),
    .eret    (eret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    int_ack = 1'b0; eret = 1'b0; irq_in = '0;
    tick();

    // 1: reset with all sources high
    rst = 1'b1; irq_in = 6'h3F;
    tick();
    rst = 1'b0; irq_in = '0;
    rd(IC_MASK, v); chk("rst_mask", v, 32'h0);
    rd(IC_PEND, v); chk("rst_pend", v, 32'h0);
    rd(IC_EDGE, v); chk("rst_edge", v, 32'h0);
    rd(IC_ISR,  v); chk("rst_isr",  v, 32'h0);
    chk("rst_hw", {26'd0, hw_int}, 32'h0);
    chk("rdata_nosel", rdata, 32'h0);

    // 2: single edge source, latency N+3
    wr(IC_MASK, 32'h3F);
    wr(IC_EDGE, 32'h3F);
    rd(IC_MASK, v); chk("mask_rb", v, 32'h3F);
    irq_in = 6'h08; tick(); irq_in = '0;
    chk("lat_n1", {26'd0, hw_int}, 32'h0);
    tick();
    chk("lat_n2", {26'd0, hw_int}, 32'h0);
    tick();
    chk("lat_n3", {26'd0, hw_int}, 32'h08);
    ack();
    rd(IC_PEND, v); chk("t2_pend_ack", v, 32'h0);
    rd(IC_ISR, v);  chk("t2_isr_svc", v, 32'h8000_0003);
    chk("t2_hw_svc", {26'd0, hw_int}, 32'h0);
    do_eret();
    rd(IC_ISR, v);  chk("t2_isr_eret", v, 32'h0);

    // 3: two sources same cycle, src1 beats src4
    irq_in = 6'b010010; tick(); irq_in = '0;
    rd(IC_PEND, v); chk("t3_pend", v, 32'h12);
    tick(); tick();
    chk("t3_hw_first", {26'd0, hw_int}, 32'h02);
    ack();
    rd(IC_PEND, v); chk("t3_pend_ack", v, 32'h10);
    do_eret();
    tick();
    chk("t3_hw_e1", {26'd0, hw_int}, 32'h0);
    tick();
    chk("t3_hw_second", {26'd0, hw_int}, 32'h10);
    ack(); do_eret();

    // 4: level src2 re-requests until W1C
    wr(IC_EDGE, 32'h3B);
    irq_in = 6'h04; tick();
    tick(); tick();
    chk("t4_hw_lvl", {26'd0, hw_int}, 32'h04);
    ack();
    rd(IC_PEND, v); chk("t4_pend_kept", v, 32'h04);
    rd(IC_ISR, v);  chk("t4_isr", v, 32'h8000_0002);
    do_eret();
    tick(); tick();
    chk("t4_hw_rereq", {26'd0, hw_int}, 32'h04);
    irq_in = '0;
    wr(IC_PEND, 32'h4);
    rd(IC_PEND, v); chk("t4_pend_w1c", v, 32'h0);
    tick();
    chk("t4_hw_drop", {26'd0, hw_int}, 32'h0);
    rd(IC_ISR, v);  chk("t4_isr_idle", v, 32'h0);

    // 5: mask drop while requesting src5
    wr(IC_EDGE, 32'h3F);
    irq_in = 6'h20; tick(); irq_in = '0;
    tick(); tick();
    chk("t5_hw_req", {26'd0, hw_int}, 32'h20);
    wr(IC_MASK, 32'h1F);
    tick();
    chk("t5_hw_masked", {26'd0, hw_int}, 32'h0);
    rd(IC_PEND, v); chk("t5_pend_kept", v, 32'h20);
    tick();
    chk("t5_hw_still0", {26'd0, hw_int}, 32'h0);
    wr(IC_MASK, 32'h3F);
    tick(); tick();
    chk("t5_hw_resume", {26'd0, hw_int}, 32'h20);
    ack(); do_eret();

    // 6: set beats W1C on src0; eret in REQ ignored; reset during SVC
    irq_in = 6'h01;
    wr(IC_PEND, 32'h1);
    irq_in = '0;
    rd(IC_PEND, v); chk("t6_set_wins", v, 32'h01);
    tick(); tick();
    chk("t6_hw_req", {26'd0, hw_int}, 32'h01);
    do_eret();
    chk("t6_eret_in_req", {26'd0, hw_int}, 32'h01);
    ack();
    rd(IC_ISR, v);  chk("t6_isr_svc", v, 32'h8000_0000);
    irq_in = 6'h02; tick(); irq_in = '0;
    rd(IC_PEND, v); chk("t6_pend_in_svc", v, 32'h02);
    chk("t6_hw_svc", {26'd0, hw_int}, 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    rd(IC_PEND, v); chk("t6_rst_pend", v, 32'h0);
    rd(IC_ISR, v);  chk("t6_rst_isr", v, 32'h0);
    rd(IC_MASK, v); chk("t6_rst_mask", v, 32'h0);
    chk("t6_rst_hw", {26'd0, hw_int}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
